fmap_window_reader: RTL

Reader side of the per-channel layer result memory. After pooling completes, it scans one pooled feature map, issues paired read requests (load, addr1, addr2) to the memory's two read ports, and assembles 3x3 convolution windows. It presents one window per output position to the next conv layer over a valid/ready handshake, in raster order, one channel per run.

---
 rtl/fmap_window_reader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fmap_window_reader.sv
// fmap_window_reader: scans one pooled feature map, issues paired reads to the
// two-port layer result memory, and presents 3x3 windows in raster order
// over a valid/ready handshake.
module fmap_window_reader #(
  parameter int MAP_DIM    = 14,
  parameter int ROW_STRIDE = 56,
  parameter int COL_STRIDE = 2,
  parameter int K          = 3,
  parameter int ADDR_W     = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          ch_sel,
  output logic                busy,
  output logic                done,
  output logic [3:0]          mem_ch,
  output logic                mem_load,
  output logic [ADDR_W-1:0]   mem_addr1,
  output logic [ADDR_W-1:0]   mem_addr2,
  input  logic signed [7:0]   mem_data1,
  input  logic signed [7:0]   mem_data2,
  output logic [8*K*K-1:0]    win,
  output logic [3:0]          out_row,
  output logic [3:0]          out_col,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int TAPS    = K * K;
  localparam int PAIRS   = (TAPS + 1) / 2;
  localparam int OUT_DIM = MAP_DIM - K + 1;
  localparam logic [3:0] LAST_POS  = 4'(OUT_DIM - 1);
  localparam logic [2:0] LAST_PAIR = 3'(PAIRS - 1);

  typedef enum logic [2:0] {IDLE, READ, LAST, PRESENT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  p_reg, p_next;
  logic [3:0]  r_reg, r_next;
  logic [3:0]  c_reg, c_next;
  logic [3:0]  ch_reg, ch_next;
  logic        cap_en;
  int          cap_pair;
  int          t1, t2;
  logic [7:0]  tap_reg [TAPS];

  // Address of tap t for output position (row, col); kept at ADDR_W bits.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [3:0] row,
                                                 input logic [3:0] col,
                                                 input int t);
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] ca;
    ra = ADDR_W'(row) + ADDR_W'(t / K);
    ca = ADDR_W'(col) + ADDR_W'(t % K);
    return ra * ADDR_W'(ROW_STRIDE) + ca * ADDR_W'(COL_STRIDE);
  endfunction

  // State and scan-position registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      p_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      ch_reg    <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      ch_reg    <= ch_next;
    end
  end

  // Next-state, scan advance, memory requests and capture control.
  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    r_next     = r_reg;
    c_next     = c_reg;
    ch_next    = ch_reg;
    mem_load   = 1'b0;
    mem_addr1  = '0;
    mem_addr2  = '0;
    cap_en     = 1'b0;
    cap_pair   = 0;
    t1         = 2 * int'(p_reg);
    t2         = (t1 + 1 >= TAPS) ? TAPS - 1 : t1 + 1;
    case (state_reg)
      IDLE: begin
        if (start) begin
          ch_next    = ch_sel;
          r_next     = '0;
          c_next     = '0;
          p_next     = '0;
          state_next = READ;
        end
      end
      READ: begin
        mem_load  = 1'b1;
        mem_addr1 = tap_addr(r_reg, c_reg, t1);
        // Final pair has an odd tap left; port 2 repeats it and is ignored.
        mem_addr2 = tap_addr(r_reg, c_reg, t2);
        // Memory answers one cycle late, so the previous pair lands now.
        cap_en    = (p_reg != 3'd0);
        cap_pair  = int'(p_reg) - 1;
        if (p_reg == LAST_PAIR) begin
          p_next     = '0;
          state_next = LAST;
        end else begin
          p_next = p_reg + 3'd1;
        end
      end
      LAST: begin
        cap_en     = 1'b1;
        cap_pair   = PAIRS - 1;
        state_next = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          if (r_reg == LAST_POS && c_reg == LAST_POS) begin
            state_next = DONE;
          end else begin
            if (c_reg == LAST_POS) begin
              c_next = '0;
              r_next = r_reg + 4'd1;
            end else begin
              c_next = c_reg + 4'd1;
            end
            state_next = READ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Window tap registers; even taps come from port 1, odd taps from port 2.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
    if (gi % 2 == 0) begin : g_even
      // Capture even tap from port 1 when its pair returns.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) tap_reg[gi] <= '0;
        else if (cap_en && cap_pair == gi / 2) tap_reg[gi] <= mem_data1;
      end
    end else begin : g_odd
      // Capture odd tap from port 2 when its pair returns.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) tap_reg[gi] <= '0;
        else if (cap_en && cap_pair == gi / 2) tap_reg[gi] <= mem_data2;
      end
    end
    assign win[gi*8 +: 8] = tap_reg[gi];
  end

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign out_valid = (state_reg == PRESENT);
  assign out_row   = r_reg;
  assign out_col   = c_reg;
  assign mem_ch    = ch_reg;

endmodule
